// File: rtl/gb_oam_dma_pkg.sv
// gb_oam_dma_pkg: shared constants, state encoding and source remap for the OAM DMA block
package gb_oam_dma_pkg;
    localparam logic [15:0] DMA_REG_ADR = 16'hFF46;
    localparam int          OAM_BYTES   = 160;
    localparam logic [7:0]  HIGH_PAGE   = 8'hFF;

    typedef enum logic [1:0] {IDLE, START, XFER} dma_state_t;

    // Sources 0xE0-0xFF alias echo RAM onto WRAM 0xC0-0xDF
    function automatic logic [7:0] eff_src(input logic [7:0] s);
        return (s[7:5] == 3'b111) ? {3'b110, s[4:0]} : s;
    endfunction
endpackage

// File: rtl/gb_oam_dma.sv
// gb_oam_dma: 0xFF46-triggered 160-byte copy into OAM; owns the bus and blocks CPU
// accesses below 0xFF00 while the copy runs
module gb_oam_dma
    import gb_oam_dma_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_adr,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic [15:0] bus_adr,
    output logic        bus_read,
    output logic        bus_write,
    input  logic [7:0]  bus_din,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_dout,
    output logic        oam_write,
    output logic [7:0]  reg_dout,
    output logic        dma_active
);
    localparam int SW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0] IDX_LAST = 8'(OAM_BYTES - 1);

    dma_state_t state, state_nx;
    logic [7:0] src, src_nx, idx, idx_nx;
    logic [SW-1:0] slot, slot_nx;
    logic trig, slot_end, xfer, cpu_low;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            src   <= 8'hFF;
            idx   <= '0;
            slot  <= '0;
        end else begin
            state <= state_nx;
            src   <= src_nx;
            idx   <= idx_nx;
            slot  <= slot_nx;
        end
    end

    // A trigger write overrides whatever the current state wanted next
    always_comb begin
        trig     = cpu_write && (cpu_adr == DMA_REG_ADR);
        slot_end = (slot == SLOT_LAST);
        state_nx = state;
        src_nx   = src;
        idx_nx   = idx;
        slot_nx  = slot_end ? '0 : slot + 1'b1;
        if (trig) begin
            state_nx = START;
            src_nx   = cpu_dout;
            idx_nx   = '0;
            slot_nx  = '0;
        end else if (state == START) begin
            state_nx = slot_end ? XFER : START;
        end else if (state == XFER) begin
            idx_nx   = (slot_end && idx != IDX_LAST) ? idx + 8'd1 : idx;
            state_nx = (slot_end && idx == IDX_LAST) ? IDLE : XFER;
        end else begin
            slot_nx  = '0;
        end
    end

    always_comb begin
        xfer       = (state == XFER) && !reset;
        cpu_low    = (cpu_adr[15:8] != HIGH_PAGE);
        dma_active = xfer;
        oam_write  = xfer && slot_end;
        oam_adr    = idx;
        oam_dout   = bus_din;
        bus_adr    = xfer ? {eff_src(src), idx} : cpu_adr;
        bus_read   = xfer ? 1'b1 : cpu_read;
        bus_write  = xfer ? 1'b0 : cpu_write;
        cpu_din    = (xfer && cpu_low) ? 8'hFF : bus_din;
        reg_dout   = src;
    end
endmodule

// File: tb/tb_gb_oam_dma.sv
// tb_gb_oam_dma: directed checks of gb_oam_dma at 4, 1 and 8 clocks per byte
module tb_gb_oam_dma;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] cpu_adr = '0;
    logic cpu_read = 1'b0, cpu_write = 1'b0;
    logic [7:0] cpu_dout = '0;
    logic [7:0] cpu_din[3], bus_din[3], oam_adr[3], oam_dout[3], reg_dout[3];
    logic [15:0] bus_adr[3];
    logic bus_read[3], bus_write[3], oam_write[3], dma_active[3];
    logic [7:0] mem[65536];
    logic [7:0] alog[3][4096], dlog[3][4096];
    logic [15:0] blog[3][4096];
    int act_cnt[3], wr_cnt[3], dly[3];
    int checks = 0, errors = 0;
    int w, a, w1, w2, a1, a2;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        gb_oam_dma #(.CYCLES_PER_BYTE(g == 0 ? 4 : g == 1 ? 1 : 8)) u (
            .clk(clk), .reset(reset), .cpu_adr(cpu_adr), .cpu_read(cpu_read),
            .cpu_write(cpu_write), .cpu_dout(cpu_dout), .cpu_din(cpu_din[g]),
            .bus_adr(bus_adr[g]), .bus_read(bus_read[g]), .bus_write(bus_write[g]),
            .bus_din(bus_din[g]), .oam_adr(oam_adr[g]), .oam_dout(oam_dout[g]),
            .oam_write(oam_write[g]), .reg_dout(reg_dout[g]), .dma_active(dma_active[g])
        );
    end

    always_comb for (int k = 0; k < 3; k++) bus_din[k] = mem[bus_adr[k]];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dma_active[k]) act_cnt[k]++;
            if (oam_write[k]) begin
                alog[k][wr_cnt[k] & 4095] = oam_adr[k];
                dlog[k][wr_cnt[k] & 4095] = oam_dout[k];
                blog[k][wr_cnt[k] & 4095] = bus_adr[k];
                wr_cnt[k]++;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic trigger(input logic [7:0] s);
        cpu_adr = 16'hFF46;
        cpu_dout = s;
        cpu_write = 1'b1;
        tick(1);
        cpu_write = 1'b0;
        cpu_adr = 16'h0000;
    endtask

    task automatic measure();
        dly = '{0, 0, 0};
        repeat (12) begin
            for (int k = 0; k < 3; k++) if (!dma_active[k]) dly[k]++;
            tick(1);
        end
    endtask

    task automatic wait_wr(input int k, input int n, input int lim);
        int c = 0;
        while (wr_cnt[k] < n && c < lim) begin
            tick(1);
            c++;
        end
        check("wait_wr", wr_cnt[k], n);
    endtask

    function automatic int byte_err(input int k, input int w0, input logic [15:0] base);
        int e = 0;
        for (int i = 0; i < 160; i++) begin
            int j = (w0 + i) & 4095;
            if (alog[k][j] !== 8'(i) || dlog[k][j] !== mem[base + 16'(i)]) e++;
        end
        return e;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
            mem[16'h8000 + 16'(i)] = 8'(i * 3 + 7);
            mem[16'hC100 + 16'(i)] = ~8'(i);
            mem[16'hE100 + 16'(i)] = 8'hEE;
        end
        mem[16'h1234] = 8'h3C;
        tick(2);
        check("rst_reg", reg_dout[0], 8'hFF);
        check("rst_active", dma_active[0], 0);
        check("rst_oamwr", oam_write[0], 0);
        reset = 1'b0;
        cpu_adr = 16'h1234;
        cpu_read = 1'b1;
        tick(1);
        check("idle_adr", bus_adr[0], 16'h1234);
        check("idle_rd", bus_read[0], 1);
        check("idle_din", cpu_din[0], 8'h3C);
        cpu_read = 1'b0;

        w = wr_cnt[0];
        a = act_cnt[0];
        trigger(8'hC0);
        measure();
        check("basic_dly", dly[0], 4);
        cpu_adr = 16'hC010;
        cpu_read = 1'b1;
        #1;
        check("blk_din", cpu_din[0], 8'hFF);
        check("blk_rd", bus_read[0], 1);
        check("blk_adr_lo", bus_adr[0][15:8], 8'hC0);
        cpu_adr = 16'hFF80;
        #1;
        check("blk_adr_hi", bus_adr[0][15:8], 8'hC0);
        cpu_read = 1'b0;
        cpu_adr = 16'h8000;
        cpu_dout = 8'h77;
        cpu_write = 1'b1;
        #1;
        check("blk_wr", bus_write[0], 0);
        check("blk_wr_adr", bus_adr[0][15:8], 8'hC0);
        tick(1);
        cpu_write = 1'b0;
        cpu_adr = 16'h0000;
        wait_wr(0, w + 160, 2000);
        tick(4);
        check("basic_act", act_cnt[0] - a, 640);
        check("basic_cnt", wr_cnt[0] - w, 160);
        check("basic_bytes", byte_err(0, w, 16'hC000), 0);
        check("basic_first", dlog[0][w & 4095], 8'h5A);
        check("basic_last", dlog[0][(w + 159) & 4095], 8'hC5);
        check("basic_done", dma_active[0], 0);

        trigger(8'hC0);
        w = wr_cnt[0];
        wait_wr(0, w + 50, 1000);
        trigger(8'h80);
        w = wr_cnt[0];
        a = act_cnt[0];
        measure();
        check("rst_dly", dly[0], 4);
        wait_wr(0, w + 160, 2000);
        tick(4);
        check("restart_act", act_cnt[0] - a, 640);
        check("restart_cnt", wr_cnt[0] - w, 160);
        check("restart_adr0", alog[0][w & 4095], 0);
        check("restart_bytes", byte_err(0, w, 16'h8000), 0);

        w = wr_cnt[0];
        a = act_cnt[0];
        trigger(8'hE1);
        check("echo_reg", reg_dout[0], 8'hE1);
        wait_wr(0, w + 160, 2000);
        tick(4);
        check("echo_act", act_cnt[0] - a, 640);
        check("echo_bytes", byte_err(0, w, 16'hC100), 0);
        check("echo_adr0", blog[0][w & 4095], 16'hC100);
        check("echo_adr159", blog[0][(w + 159) & 4095], 16'hC19F);

        trigger(8'hC0);
        w = wr_cnt[0];
        wait_wr(0, w + 80, 1000);
        reset = 1'b1;
        #1;
        check("mrst_active", dma_active[0], 0);
        check("mrst_oamwr", oam_write[0], 0);
        tick(1);
        reset = 1'b0;
        check("mrst_after", dma_active[0], 0);
        check("mrst_reg", reg_dout[0], 8'hFF);
        w = wr_cnt[0];
        a = act_cnt[0];
        cpu_adr = 16'hC000;
        cpu_read = 1'b1;
        #1;
        check("mrst_pass_adr", bus_adr[0], 16'hC000);
        check("mrst_pass_din", cpu_din[0], 8'h5A);
        tick(700);
        cpu_read = 1'b0;
        check("mrst_no_wr", wr_cnt[0] - w, 0);
        check("mrst_no_act", act_cnt[0] - a, 0);

        w1 = wr_cnt[1];
        w2 = wr_cnt[2];
        a1 = act_cnt[1];
        a2 = act_cnt[2];
        trigger(8'hC0);
        measure();
        check("cpb1_dly", dly[1], 1);
        check("cpb8_dly", dly[2], 8);
        wait_wr(2, w2 + 160, 3000);
        tick(10);
        check("cpb1_act", act_cnt[1] - a1, 160);
        check("cpb8_act", act_cnt[2] - a2, 1280);
        check("cpb1_cnt", wr_cnt[1] - w1, 160);
        check("cpb8_cnt", wr_cnt[2] - w2, 160);
        check("cpb1_bytes", byte_err(1, w1, 16'hC000), 0);
        check("cpb8_bytes", byte_err(2, w2, 16'hC000), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
